// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and
// tracks reserved destinations in a busy scoreboard for hazard checks.
module regfile_write_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        write_enable,
  output logic [4:0]  address_e,
  output logic [31:0] data,
  output logic [5:0]  pending_count
);

  logic        last_b;
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        a_grant;
  logic        b_grant;
  logic        grant;
  logic [4:0]  g_addr;
  logic [31:0] g_data;

  // Readiness looks only at the valids and the last-grant flag, never at payload.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (reset_n) begin
      if (ROUND_ROBIN != 0) begin
        a_ready = !b_valid || last_b;
        b_ready = !a_valid || !last_b;
      end else begin
        a_ready = 1'b1;
        b_ready = !a_valid;
      end
    end
  end

  assign a_grant = a_valid && a_ready;
  assign b_grant = b_valid && b_ready;
  assign grant   = a_grant || b_grant;
  assign g_addr  = a_grant ? a_addr : b_addr;
  assign g_data  = a_grant ? a_data : b_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (a_grant) begin
      last_b <= 1'b0;
    end else if (b_grant) begin
      last_b <= 1'b1;
    end
  end

  // Address 0 is accepted but never written; address/data hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_enable <= 1'b0;
      address_e    <= 5'd0;
      data         <= 32'd0;
    end else begin
      write_enable <= grant && (g_addr != 5'd0);
      if (grant && (g_addr != 5'd0)) begin
        address_e <= g_addr;
        data      <= g_data;
      end
    end
  end

  // A new reservation overrides a same-cycle clear of the same register.
  always_comb begin
    busy_next = busy;
    if (grant) begin
      busy_next[g_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    pending_count = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pending_count = pending_count + {5'd0, busy[i]};
    end
  end

  // The in-flight write still counts as busy so a reader never sees stale data.
  assign q_busy1 = busy[q_addr1] || (write_enable && (address_e == q_addr1));
  assign q_busy2 = busy[q_addr2] || (write_enable && (address_e == q_addr2));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic        a_valid, b_valid, rsv_valid;
  logic [4:0]  a_addr, b_addr, rsv_addr, q_addr1, q_addr2;
  logic [31:0] a_data, b_data;

  logic        a_ready, b_ready, q_busy1, q_busy2, write_enable;
  logic [4:0]  address_e;
  logic [31:0] data;
  logic [5:0]  pending_count;

  logic        fp_a_ready, fp_b_ready, fp_q_busy1, fp_q_busy2, fp_write_enable;
  logic [4:0]  fp_address_e;
  logic [31:0] fp_data;
  logic [5:0]  fp_pending_count;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .write_enable(write_enable), .address_e(address_e), .data(data),
    .pending_count(pending_count)
  );

  regfile_write_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(fp_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(fp_b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(fp_q_busy1), .q_busy2(fp_q_busy2),
    .write_enable(fp_write_enable), .address_e(fp_address_e), .data(fp_data),
    .pending_count(fp_pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [4:0] exp_addr;
    reset_n = 1'b0;
    a_valid = 0; b_valid = 0; rsv_valid = 0;
    a_addr = 0; b_addr = 0; rsv_addr = 0; q_addr1 = 0; q_addr2 = 0;
    a_data = 0; b_data = 0;

    #3;
    a_valid = 1; b_valid = 1;
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_fp_a_ready", fp_a_ready, 0);
    check("rst_we", write_enable, 0);
    check("rst_addr", address_e, 0);
    check("rst_data", data, 0);
    check("rst_count", pending_count, 0);
    #19;
    a_valid = 0; b_valid = 0;
    reset_n = 1'b1;
    step();

    // single A write
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #4;
    check("a_only_ready", a_ready, 1);
    check("a_only_fp_ready", fp_a_ready, 1);
    step();
    a_valid = 0;
    check("a_only_we", write_enable, 1);
    check("a_only_addr", address_e, 5);
    check("a_only_data", data, 32'hDEADBEEF);

    // single B write leaves last grant = B
    b_valid = 1; b_addr = 1; b_data = 32'h11;
    #4;
    check("b_only_ready", b_ready, 1);
    step();
    b_valid = 0;
    check("b_only_we", write_enable, 1);
    check("b_only_addr", address_e, 1);

    // contention: round-robin alternates, fixed priority always A
    a_valid = 1; a_addr = 3; a_data = 32'h33;
    b_valid = 1; b_addr = 4; b_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
      check("fp_a_ready", fp_a_ready, 1);
      check("fp_b_ready", fp_b_ready, 0);
      step();
      exp_addr = (i % 2 == 0) ? 5'd3 : 5'd4;
      check("rr_we", write_enable, 1);
      check("rr_addr", address_e, exp_addr);
      check("fp_addr", fp_address_e, 3);
      check("fp_data", fp_data, 32'h33);
    end
    a_valid = 0; b_valid = 0;
    step();
    check("idle_we", write_enable, 0);
    check("idle_addr_hold", address_e, 4);
    check("idle_data_hold", data, 32'h44);
    check("idle_fp_we", fp_write_enable, 0);

    // reserve 7, then B writes it back
    rsv_valid = 1; rsv_addr = 7;
    step();
    rsv_valid = 0; q_addr1 = 7;
    #1;
    check("rsv7_busy", q_busy1, 1);
    check("rsv7_count", pending_count, 1);
    b_valid = 1; b_addr = 7; b_data = 32'h77;
    #3;
    check("wb7_ready", b_ready, 1);
    step();
    b_valid = 0;
    check("wb7_we", write_enable, 1);
    check("wb7_busy_during_write", q_busy1, 1);
    check("wb7_count", pending_count, 0);
    step();
    check("wb7_busy_after", q_busy1, 0);
    check("wb7_we_after", write_enable, 0);

    // same-cycle reserve and clear of 9
    rsv_valid = 1; rsv_addr = 9;
    step();
    rsv_valid = 0; q_addr2 = 9;
    check("rsv9_count", pending_count, 1);
    rsv_valid = 1; rsv_addr = 9;
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    step();
    rsv_valid = 0; a_valid = 0;
    check("rsvclr9_busy", q_busy2, 1);
    check("rsvclr9_count", pending_count, 1);
    check("rsvclr9_we", write_enable, 1);
    step();
    check("rsvclr9_busy_later", q_busy2, 1);
    check("rsvclr9_count_later", pending_count, 1);

    // reserve of register 0 is ignored
    rsv_valid = 1; rsv_addr = 0;
    step();
    rsv_valid = 0; q_addr1 = 0;
    #1;
    check("rsv0_count", pending_count, 1);
    check("rsv0_busy", q_busy1, 0);

    // write to register 0 is accepted but not performed
    a_valid = 1; a_addr = 0; a_data = 32'hAA;
    #3;
    check("wr0_ready", a_ready, 1);
    step();
    a_valid = 0;
    check("wr0_we", write_enable, 0);

    // re-reserve of a set bit
    rsv_valid = 1; rsv_addr = 9;
    step();
    rsv_valid = 0;
    check("rersv9_count", pending_count, 1);

    // clear of an unset bit; last grant becomes A
    a_valid = 1; a_addr = 12; a_data = 32'hC;
    step();
    a_valid = 0;
    check("clr12_count", pending_count, 1);
    check("clr12_addr", address_e, 12);

    rsv_valid = 1; rsv_addr = 15;
    step();
    rsv_valid = 0;
    check("rsv15_count", pending_count, 2);

    // reset between grant and write edge
    a_valid = 1; a_addr = 20; a_data = 32'h1234;
    #3;
    check("abort_ready", a_ready, 1);
    reset_n = 1'b0;
    #1;
    check("abort_a_ready_rst", a_ready, 0);
    check("abort_b_ready_rst", b_ready, 0);
    step();
    check("abort_we", write_enable, 0);
    check("abort_addr", address_e, 0);
    check("abort_data", data, 0);
    check("abort_count", pending_count, 0);
    check("abort_busy", q_busy2, 0);
    a_valid = 0;
    #3;
    reset_n = 1'b1;
    step();
    check("post_rst_we", write_enable, 0);

    // last-grant flag reset to B so A wins first contention
    a_valid = 1; b_valid = 1;
    #3;
    check("post_rst_a_wins", a_ready, 1);
    check("post_rst_b_stall", b_ready, 0);
    step();
    a_valid = 0; b_valid = 0;
    check("post_rst_addr", address_e, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
